// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex scanner for common-anode seven-segment digits.
// Define HEX_SCAN_LZB_EN to enable leading-zero blanking.
module hex_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [3:0]              digit_nibble,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_done
);

    localparam int PH_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PH_W-1:0]  PH_MAX   = PH_W'(REFRESH_DIV - 1);
    localparam logic [PH_W-1:0]  PH_BLANK = PH_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

    logic [PH_W-1:0]         ph_q, ph_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   anode_n_q, anode_n_d;
    logic [3:0]              nibble_q, nibble_d;
    logic                    frame_done_q, frame_done_d;

    logic                    ph_wrap;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   lit;

    always_comb begin
        ph_wrap  = (ph_q == PH_MAX);
        boundary = ph_wrap && (idx_q == IDX_MAX);
        load_ready = boundary && !rst;

        ph_d = ph_wrap ? '0 : ph_q + 1'b1;

        idx_d = idx_q;
        if (ph_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        shadow_d = shadow_q;
        if (boundary && load_valid) begin
            shadow_d = value_in;
        end

        frame_done_d = boundary;
    end

`ifdef HEX_SCAN_LZB_EN
    // A digit stays dark when it and every digit above it are zero.
    always_comb begin
        logic nz;
        nz  = 1'b0;
        lit = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nz     = nz | (|shadow_d[4*k +: 4]);
            lit[k] = nz | (k == 0);
        end
    end
`else
    always_comb begin
        lit = '1;
    end
`endif

    // Outputs are computed from next-state so they line up with ph/idx.
    always_comb begin
        anode_n_d = '1;
        if (ph_d >= PH_BLANK) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_d == IDX_W'(k) && lit[k]) begin
                    anode_n_d[k] = 1'b0;
                end
            end
        end
        nibble_d = shadow_d[4*idx_d +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q         <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            anode_n_q    <= '1;
            nibble_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            ph_q         <= ph_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            anode_n_q    <= anode_n_d;
            nibble_q     <= nibble_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode_n      = anode_n_q;
    assign digit_nibble = nibble_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: table vectors, hand sequences and random
// traffic checked against a frame-position reference model.
module tb_hex_display_scanner;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FL = ND * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  digit_nibble;
    logic [3:0]  anode_n;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Model state: cycles since reset, displayed value, pending frame pulse.
    int          t   = 0;
    logic [15:0] sh  = '0;
    logic        fdm = 1'b0;

    hex_display_scanner #(
        .NUM_DIGITS(ND),
        .REFRESH_DIV(RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value_in(value_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .digit_nibble(digit_nibble),
        .anode_n(anode_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic int pos();
        return t % FL;
    endfunction

    function automatic logic [3:0] exp_anode();
        int p, s;
        logic on;
        p = pos();
        s = p / RD;
        if ((p % RD) < BC) return 4'hF;
`ifdef HEX_SCAN_LZB_EN
        on = (s == 0) || ((sh >> (4 * s)) != 0);
`else
        on = 1'b1;
`endif
        return on ? ~(4'(1) << s) : 4'hF;
    endfunction

    function automatic logic [3:0] exp_nibble();
        return 4'((sh >> (4 * (pos() / RD))) & 16'hF);
    endfunction

    task automatic check(input string nm, input logic [15:0] got,
                         input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, t, got, want);
        end
    endtask

    // One clock: drive at negedge, check handshake, advance, check outputs.
    task automatic cyc(input logic r, input logic v, input logic [15:0] val);
        logic rdy;
        rst = r;
        load_valid = v;
        value_in = val;
        #1;
        rdy = !r && (pos() == FL - 1);
        check("load_ready", 16'(load_ready), 16'(rdy));
        @(posedge clk);
        if (r) begin
            t = 0;
            sh = '0;
            fdm = 1'b0;
        end else begin
            fdm = (pos() == FL - 1);
            if (rdy && v) sh = val;
            t++;
        end
        @(negedge clk);
        check("anode_n", 16'(anode_n), 16'(exp_anode()));
        check("digit_nibble", 16'(digit_nibble), 16'(exp_nibble()));
        check("frame_done", 16'(frame_done), 16'(fdm));
    endtask

    typedef struct {
        logic [15:0] val;
        logic [15:0] nib;
        logic [15:0] an;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{16'h1234, 16'h1234, 16'h7BDE};
        vecs[1] = '{16'hABCD, 16'hABCD, 16'h7BDE};
`ifdef HEX_SCAN_LZB_EN
        vecs[2] = '{16'h0050, 16'h0050, 16'hFFDE};
        vecs[3] = '{16'h0000, 16'h0000, 16'hFFFE};
`else
        vecs[2] = '{16'h0050, 16'h0050, 16'h7BDE};
        vecs[3] = '{16'h0000, 16'h0000, 16'h7BDE};
`endif

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'hFFFF);

        foreach (vecs[i]) begin
            while (pos() != FL - 1) cyc(1'b0, 1'b1, vecs[i].val);
            cyc(1'b0, 1'b1, vecs[i].val);
            check("frame_start_pos", 16'(pos()), 16'd0);
            for (int c = 0; c < FL; c++) begin
                cyc(1'b0, 1'b0, 16'($urandom));
                if (pos() % RD == 4) begin
                    check("tbl_nibble", 16'(digit_nibble),
                          16'(vecs[i].nib[4*(pos()/RD) +: 4]));
                    check("tbl_anode", 16'(anode_n),
                          16'(vecs[i].an[4*(pos()/RD) +: 4]));
                end
            end
        end

        // Load mid-frame request, then reset in digit 2's SHOW phase.
        while (pos() != 5) cyc(1'b0, 1'b0, 16'h0);
        while (pos() != FL - 1) cyc(1'b0, 1'b1, 16'h9876);
        cyc(1'b0, 1'b1, 16'h9876);
        while (pos() != 20) cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 16'h0);
        check("rst_mid_anode", 16'(anode_n), 16'hF);
        for (int c = 0; c < FL + 4; c++) cyc(1'b0, 1'b0, 16'($urandom));

        for (int c = 0; c < 1500; c++) begin
            cyc(($urandom_range(0, 60) == 0), 1'($urandom),
                16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
